// File: rtl/ats21_pkg.sv
// Shared constants and the event payload for the ATS21 alarm collector.
// Build option: ATS21_COLLECTOR_TIMESTAMP_EN adds a 16-bit capture timestamp
// to every event.
package ats21_pkg;

  localparam int unsigned NUM_ALARMS_DEF = 24;
  localparam int unsigned ALARM_ID_W     = 5;
  localparam int unsigned TS_W           = 16;

  // One queued alarm event
  typedef struct packed {
    logic [ALARM_ID_W-1:0] id;
`ifdef ATS21_COLLECTOR_TIMESTAMP_EN
    logic [TS_W-1:0]       ts;
`endif
  } evt_t;

endpackage

// File: rtl/ats21_alarm_collector_if.sv
// Event-side bus of the alarm collector: consumer pop plus head-event view.
// Ports (master = collector, slave = consumer):
//   pop        consumer -> collector  dequeue head event
//   evt_valid  collector -> consumer  head event valid
//   evt_id     collector -> consumer  alarm index of head event
//   evt_count  collector -> consumer  number of queued events
//   irq        collector -> consumer  level interrupt, mirrors evt_valid
//   evt_ts     collector -> consumer  capture timestamp (ATS21_COLLECTOR_TIMESTAMP_EN only)
interface ats21_alarm_collector_if #(
  parameter int unsigned DEPTH = 8
) ();

  logic                                 pop;
  logic                                 evt_valid;
  logic [ats21_pkg::ALARM_ID_W-1:0]     evt_id;
  logic [$clog2(DEPTH+1)-1:0]           evt_count;
  logic                                 irq;
`ifdef ATS21_COLLECTOR_TIMESTAMP_EN
  logic [ats21_pkg::TS_W-1:0]           evt_ts;

  modport master (input pop, output evt_valid, evt_id, evt_count, irq, evt_ts);
  modport slave  (output pop, input evt_valid, evt_id, evt_count, irq, evt_ts);
`else
  modport master (input pop, output evt_valid, evt_id, evt_count, irq);
  modport slave  (output pop, input evt_valid, evt_id, evt_count, irq);
`endif

endinterface

// File: rtl/ats21_evt_fifo.sv
// Event FIFO with (log2(DEPTH)+1)-bit wrapping pointers; full/empty from the
// pointer MSB. A push into a full FIFO is accepted only alongside a real pop.
// Ports:
//   clk_1x, reset  clock, async active-high reset
//   push, din      enqueue request and payload
//   pop            dequeue request (ignored when empty)
//   full, empty    status
//   count          number of stored entries
//   head           oldest entry, zero when empty
module ats21_evt_fifo
  import ats21_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk_1x,
  input  logic             reset,
  input  logic             push,
  input  evt_t             din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output evt_t             head
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  evt_t             mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Status decode and handshake qualification
  always_comb begin
    empty   = (wptr == rptr);
    full    = (wptr[PTR_W-1] != rptr[PTR_W-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    count   = CNT_W'(wptr - rptr);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = empty ? '0 : mem[rptr[AW-1:0]];
  end

  // Pointer update
  always_ff @(posedge clk_1x or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
    end
  end

  // Storage; contents are don't-care until written
  always_ff @(posedge clk_1x) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ats21_alarm_collector.sv
// Collects rising edges of ATS21 alarm flags into a pending set and drains it
// lowest index first into an event FIFO read by a consumer.
// Build option: ATS21_COLLECTOR_TIMESTAMP_EN adds a free-running 16-bit cycle
// counter captured per firing and delivered on evt.evt_ts.
// Ports:
//   clk_1x, reset  clock, async active-high reset
//   alarm_data     per-alarm finished flags (levels)
//   clr_ovf        clear sticky overflow
//   overflow       sticky: a firing was dropped
//   evt            event bus (master side)
module ats21_alarm_collector
  import ats21_pkg::*;
#(
  parameter int unsigned NUM_ALARMS = NUM_ALARMS_DEF,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk_1x,
  input  logic                  reset,
  input  logic [NUM_ALARMS-1:0] alarm_data,
  input  logic                  clr_ovf,
  output logic                  overflow,
  ats21_alarm_collector_if.master evt
);

  logic [NUM_ALARMS-1:0] prev;
  logic [NUM_ALARMS-1:0] pending;
  logic                  armed;
  logic [NUM_ALARMS-1:0] fire;
  logic [NUM_ALARMS-1:0] accept;
  logic [NUM_ALARMS-1:0] drop;
  logic [NUM_ALARMS-1:0] sel_mask;
  logic [ALARM_ID_W-1:0] sel_id;
  logic                  push;
  logic                  fifo_full;
  logic                  fifo_empty;
  evt_t                  push_evt;
  evt_t                  head;

  // Edge detect; the first edge after reset only loads prev so levels
  // already high at release do not fire
  always_comb begin
    fire   = armed ? (alarm_data & ~prev) : '0;
    accept = fire & ~pending;
    drop   = fire & pending;
  end

  // Lowest-index pending bit wins
  always_comb begin
    sel_id   = '0;
    sel_mask = pending & (~pending + NUM_ALARMS'(1));
    for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
      if (pending[i]) sel_id = ALARM_ID_W'(i);
    end
    push = (|pending) && (!fifo_full || (evt.pop && !fifo_empty));
  end

  always_ff @(posedge clk_1x or posedge reset) begin
    if (reset) begin
      prev     <= '0;
      pending  <= '0;
      armed    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      armed   <= 1'b1;
      prev    <= alarm_data;
      pending <= (pending & ~(push ? sel_mask : '0)) | accept;
      // A drop outranks a clear in the same cycle
      if (|drop)        overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

`ifdef ATS21_COLLECTOR_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] pending_ts [NUM_ALARMS];

  always_ff @(posedge clk_1x or posedge reset) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + TS_W'(1);
  end

  // Timestamp is taken when a firing is accepted into pending
  always_ff @(posedge clk_1x) begin
    for (int i = 0; i < int'(NUM_ALARMS); i++) begin
      if (accept[i]) pending_ts[i] <= ts_cnt;
    end
  end

  always_comb begin
    push_evt.id = sel_id;
    push_evt.ts = pending_ts[sel_id];
    evt.evt_ts  = head.ts;
  end
`else
  always_comb begin
    push_evt.id = sel_id;
  end
`endif

  ats21_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_1x (clk_1x),
    .reset  (reset),
    .push   (push),
    .din    (push_evt),
    .pop    (evt.pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (evt.evt_count),
    .head   (head)
  );

  always_comb begin
    evt.evt_valid = !fifo_empty;
    evt.irq       = !fifo_empty;
    evt.evt_id    = head.id;
  end

endmodule

// File: tb/tb_ats21_alarm_collector.sv
// Directed bench for ats21_alarm_collector: a scoreboard queue of expected
// alarm ids is filled as firings are driven and drained as events are popped.
module tb_ats21_alarm_collector;

  localparam int unsigned NUM_ALARMS = 24;
  localparam int unsigned DEPTH      = 8;

  logic                  clk_1x = 1'b0;
  logic                  reset;
  logic [NUM_ALARMS-1:0] alarm_data;
  logic                  clr_ovf;
  logic                  overflow;

  ats21_alarm_collector_if #(.DEPTH(DEPTH)) evt ();

  ats21_alarm_collector #(.NUM_ALARMS(NUM_ALARMS), .DEPTH(DEPTH)) dut (
    .clk_1x     (clk_1x),
    .reset      (reset),
    .alarm_data (alarm_data),
    .clr_ovf    (clr_ovf),
    .overflow   (overflow),
    .evt        (evt)
  );

  always #5 clk_1x = ~clk_1x;

  int checks = 0;
  int passed = 0;
  int exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_1x);
  endtask

  // Compare head against scoreboard, then dequeue it for one edge
  task automatic pop_check(input string tag);
    int exp_id;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp_id = exp_q.pop_front();
      check({tag, "_valid"}, 32'(evt.evt_valid), 32'd1);
      check({tag, "_id"}, 32'(evt.evt_id), 32'(exp_id));
    end
    evt.pop = 1'b1;
    step(1);
    evt.pop = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    alarm_data = '0;
    clr_ovf    = 1'b0;
    evt.pop    = 1'b0;
    step(2);
    check("rst_valid", 32'(evt.evt_valid), 32'd0);
    check("rst_id",    32'(evt.evt_id),    32'd0);
    check("rst_count", 32'(evt.evt_count), 32'd0);
    check("rst_irq",   32'(evt.irq),       32'd0);
    check("rst_ovf",   32'(overflow),      32'd0);
    reset = 1'b0;
    step(2);

    // Single firing on bit 5, held two cycles
    alarm_data[5] = 1'b1;
    step(1);
    check("single_latency", 32'(evt.evt_valid), 32'd0);
    step(1);
    exp_q.push_back(5);
    check("single_count", 32'(evt.evt_count), 32'd1);
    check("single_irq",   32'(evt.irq),       32'd1);
    alarm_data = '0;
    step(3);
    check("single_once", 32'(evt.evt_count), 32'd1);
    pop_check("single");
    check("single_drained", 32'(evt.evt_valid), 32'd0);

    // Pop on empty FIFO is ignored
    evt.pop = 1'b1;
    step(1);
    evt.pop = 1'b0;
    check("empty_pop", 32'(evt.evt_count), 32'd0);

    // Simultaneous firing of 3, 0, 17
    alarm_data = 24'h020009;
    step(1);
    step(1);
    check("simul_cnt1", 32'(evt.evt_count), 32'd1);
    step(1);
    check("simul_cnt2", 32'(evt.evt_count), 32'd2);
    step(1);
    check("simul_cnt3", 32'(evt.evt_count), 32'd3);
    alarm_data = '0;
    exp_q.push_back(0);
    exp_q.push_back(3);
    exp_q.push_back(17);
    for (int i = 0; i < 3; i++) pop_check("simul");
    check("simul_drained", 32'(evt.evt_count), 32'd0);

    // Backpressure: ten distinct bits, FIFO holds eight
    alarm_data = '0;
    alarm_data[1] = 1'b1;  alarm_data[2] = 1'b1;  alarm_data[4] = 1'b1;
    alarm_data[6] = 1'b1;  alarm_data[8] = 1'b1;  alarm_data[10] = 1'b1;
    alarm_data[12] = 1'b1; alarm_data[14] = 1'b1; alarm_data[16] = 1'b1;
    alarm_data[20] = 1'b1;
    step(1);
    alarm_data = '0;
    step(10);
    check("bp_full",  32'(evt.evt_count), 32'd8);
    check("bp_novf",  32'(overflow),      32'd0);
    foreach (exp_q[i]) ;
    exp_q.push_back(1);  exp_q.push_back(2);  exp_q.push_back(4);
    exp_q.push_back(6);  exp_q.push_back(8);  exp_q.push_back(10);
    exp_q.push_back(12); exp_q.push_back(14);

    // Bit 7 fires, then refires while still pending -> dropped
    alarm_data[7] = 1'b1;
    step(1);
    alarm_data[7] = 1'b0;
    step(1);
    check("ovf_pre", 32'(overflow), 32'd0);
    alarm_data[7] = 1'b1;
    step(1);
    alarm_data[7] = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    // Drop and clear in the same cycle: the drop wins
    alarm_data[7] = 1'b1;
    clr_ovf       = 1'b1;
    step(1);
    clr_ovf       = 1'b0;
    alarm_data[7] = 1'b0;
    check("ovf_drop_wins", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    check("ovf_clr2", 32'(overflow), 32'd0);
    check("bp_still_full", 32'(evt.evt_count), 32'd8);
    exp_q.push_back(7);
    exp_q.push_back(16);
    exp_q.push_back(20);

    // Pop while full with pending bits: count holds, new id lands at tail
    pop_check("full_push");
    check("full_push_cnt", 32'(evt.evt_count), 32'd8);
    while (exp_q.size() > 0) pop_check("bp_drain");
    check("bp_empty",   32'(evt.evt_count), 32'd0);
    check("bp_end_ovf", 32'(overflow),      32'd0);

    // Asynchronous reset with four events queued
    alarm_data = 24'h00000F;
    step(6);
    check("rst_mid_pre", 32'(evt.evt_count), 32'd4);
    reset = 1'b1;
    #1;
    check("rst_mid_valid", 32'(evt.evt_valid), 32'd0);
    check("rst_mid_count", 32'(evt.evt_count), 32'd0);
    check("rst_mid_irq",   32'(evt.irq),       32'd0);
    step(1);
    reset = 1'b0;
    step(4);
    check("rst_hold_count", 32'(evt.evt_count), 32'd0);
    check("rst_hold_valid", 32'(evt.evt_valid), 32'd0);
    alarm_data = '0;
    step(2);
    check("rst_low_count", 32'(evt.evt_count), 32'd0);

    // Collector still works after reset
    alarm_data[2] = 1'b1;
    step(2);
    exp_q.push_back(2);
    alarm_data = '0;
    pop_check("post_rst");
    check("post_rst_empty", 32'(evt.evt_count), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
